compressor_layer_ctrl: RTL

- Per-layer sequencer in front of and behind the bit-packing compressor ring.
- Accepts a layer descriptor (value bitwidth, value count) and holds the ring's bitwidth stable for the whole layer.
- Clears the ring's packing state between layers and meters raw values into it.
- After the last real value, injects zero pad values until the final partial word is emitted; generates the downstream last flag and a layer-done pulse.

---
 rtl/compressor_layer_ctrl_pkg.sv | 43 ++++
 rtl/compressor_layer_ctrl_if.sv | 61 ++++++
 rtl/compressor_layer_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/compressor_layer_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module : compressor_layer_ctrl_pkg
// Brief  : Shared FSM encodings, port widths and descriptor check for the
//          per-layer compressor ring sequencer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package compressor_layer_ctrl_pkg;

  localparam int c_bw_port_w = 5;

  localparam logic [2:0] c_st_idle_enc   = 3'd0;
  localparam logic [2:0] c_st_clear_enc  = 3'd1;
  localparam logic [2:0] c_st_stream_enc = 3'd2;
  localparam logic [2:0] c_st_pad_enc    = 3'd3;
  localparam logic [2:0] c_st_done_enc   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = c_st_idle_enc,
    ST_CLEAR  = c_st_clear_enc,
    ST_STREAM = c_st_stream_enc,
    ST_PAD    = c_st_pad_enc,
    ST_DONE   = c_st_done_enc
  } state_t;

`ifdef USE_DBG_VIVADO
  localparam int c_dbg_fsm_w = 3;
  localparam int c_dbg_cnt_w = 32;
`endif

  // A layer is unusable if it has no values or a bitwidth the ring cannot hold.
  function automatic logic desc_illegal(
    input logic [c_bw_port_w-1:0] bw,
    input logic [c_bw_port_w:0]   max_bw,
    input logic                   num_zero
  );
    return (bw == '0) || ({1'b0, bw} > max_bw) || num_zero;
  endfunction

endpackage

`default_nettype wire

// File: rtl/compressor_layer_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : compressor_layer_ctrl_if
// Brief  : Descriptor, raw-value, ring and downstream handshake bundle.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface compressor_layer_ctrl_if
  import compressor_layer_ctrl_pkg::*;
#(
  parameter int MAXBITWIDTH     = 16,
  parameter int OUTPUT_BITWIDTH = 16,
  parameter int CNT_WIDTH       = 32
) ();

  logic                       cfg_valid;
  logic [c_bw_port_w-1:0]     cfg_bitwidth;
  logic [CNT_WIDTH-1:0]       cfg_num_values;
  logic                       cfg_ready;
  logic                       s_valid;
  logic [MAXBITWIDTH-1:0]     s_data;
  logic                       s_ready;
  logic                       cmp_clr_n;
  logic [c_bw_port_w-1:0]     cmp_bitwidth;
  logic                       cmp_valid;
  logic [MAXBITWIDTH-1:0]     cmp_data;
  logic                       cmp_out_valid;
  logic [OUTPUT_BITWIDTH-1:0] cmp_out_data;
  logic                       cmp_out_ready;
  logic                       m_valid;
  logic [OUTPUT_BITWIDTH-1:0] m_data;
  logic                       m_last;
  logic                       m_ready;
  logic                       layer_done;
  logic                       layer_err;

  modport master (
    input  cfg_valid, cfg_bitwidth, cfg_num_values,
    input  s_valid, s_data,
    input  cmp_out_valid, cmp_out_data,
    input  m_ready,
    output cfg_ready, s_ready,
    output cmp_clr_n, cmp_bitwidth, cmp_valid, cmp_data, cmp_out_ready,
    output m_valid, m_data, m_last,
    output layer_done, layer_err
  );

  modport slave (
    output cfg_valid, cfg_bitwidth, cfg_num_values,
    output s_valid, s_data,
    output cmp_out_valid, cmp_out_data,
    output m_ready,
    input  cfg_ready, s_ready,
    input  cmp_clr_n, cmp_bitwidth, cmp_valid, cmp_data, cmp_out_ready,
    input  m_valid, m_data, m_last,
    input  layer_done, layer_err
  );

endinterface

`default_nettype wire

// File: rtl/compressor_layer_ctrl.sv
//------------------------------------------------------------------------------
// Module : compressor_layer_ctrl
// Brief  : Per-layer sequencer around the bit-packing ring: clear, meter, pad
//          and frame one layer of packed words.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module compressor_layer_ctrl
  import compressor_layer_ctrl_pkg::*;
#(
  parameter int MAXBITWIDTH     = 16,
  parameter int OUTPUT_BITWIDTH = 16,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  compressor_layer_ctrl_if.master bus
);

  localparam int c_obw_log2 = $clog2(OUTPUT_BITWIDTH);
  localparam int c_prod_w   = CNT_WIDTH + c_bw_port_w;
  localparam int c_exp_w    = c_prod_w - c_obw_log2;
  localparam logic [c_bw_port_w:0] c_max_bw = (c_bw_port_w + 1)'(MAXBITWIDTH);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [c_bw_port_w-1:0] r_bw;
  logic [CNT_WIDTH-1:0]   r_num;
  logic [CNT_WIDTH-1:0]   r_vals;
  logic [CNT_WIDTH-1:0]   r_words;
  logic [c_exp_w-1:0]     r_exp;
  logic                   r_err;

  logic [c_prod_w-1:0]    w_prod;
  logic [c_exp_w-1:0]     w_exp_calc;
  logic [c_exp_w-1:0]     w_words_ext;
  logic                   w_words_full;
  logic                   w_illegal;
  logic [CNT_WIDTH-1:0]   w_vals_next;
  logic [CNT_WIDTH-1:0]   w_words_next;
  logic                   w_in_xfer;
  logic                   w_out_xfer;

  logic                   w_cfg_ready;
  logic                   w_s_ready;
  logic                   w_clr_n;
  logic                   w_cmp_valid;
  logic [MAXBITWIDTH-1:0] w_cmp_data;
  logic                   w_out_ready;
  logic                   w_m_valid;
  logic                   w_m_last;
  logic                   w_done;
  logic                   w_err;

  // Ceil-divide by the word width: drop the low bits and round up if any were set.
  assign w_prod       = c_prod_w'(bus.cfg_num_values) * c_prod_w'(bus.cfg_bitwidth);
  assign w_exp_calc   = w_prod[c_prod_w-1:c_obw_log2] + c_exp_w'(|w_prod[c_obw_log2-1:0]);
  assign w_illegal    = desc_illegal(bus.cfg_bitwidth, c_max_bw, bus.cfg_num_values == '0);
  assign w_words_ext  = c_exp_w'(r_words);
  assign w_words_full = (w_words_ext == r_exp);

  always_comb begin
    w_state_next = r_state;
    w_cfg_ready  = 1'b0;
    w_s_ready    = 1'b0;
    w_clr_n      = 1'b1;
    w_cmp_valid  = 1'b0;
    w_cmp_data   = '0;
    w_out_ready  = 1'b0;
    w_m_valid    = 1'b0;
    w_m_last     = 1'b0;
    w_done       = 1'b0;
    w_err        = 1'b0;
    w_in_xfer    = 1'b0;
    w_out_xfer   = 1'b0;
    w_vals_next  = r_vals;
    w_words_next = r_words;

    case (r_state)
      ST_IDLE: begin
        w_cfg_ready = 1'b1;
        if (bus.cfg_valid) begin
          w_state_next = w_illegal ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_clr_n      = 1'b0;
        w_state_next = ST_STREAM;
      end
      ST_STREAM: begin
        w_cmp_valid  = bus.s_valid;
        w_cmp_data   = bus.s_data;
        w_s_ready    = bus.m_ready;
        w_out_ready  = bus.m_ready;
        w_m_valid    = bus.cmp_out_valid & ~w_words_full;
        w_in_xfer    = bus.s_valid & bus.m_ready;
        w_out_xfer   = w_m_valid & bus.m_ready;
        w_vals_next  = r_vals + CNT_WIDTH'(w_in_xfer);
        w_words_next = r_words + CNT_WIDTH'(w_out_xfer);
        if (w_vals_next == r_num) begin
          w_state_next = (c_exp_w'(w_words_next) == r_exp) ? ST_DONE : ST_PAD;
        end
      end
      ST_PAD: begin
        // Pad only while no word is pending, so the ring never overshoots.
        w_cmp_valid  = ~bus.cmp_out_valid & ~w_words_full;
        w_out_ready  = bus.m_ready;
        w_m_valid    = bus.cmp_out_valid & ~w_words_full;
        w_out_xfer   = w_m_valid & bus.m_ready;
        w_words_next = r_words + CNT_WIDTH'(w_out_xfer);
        if (c_exp_w'(w_words_next) == r_exp) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_err        = r_err;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    w_m_last = w_m_valid & (w_words_ext == (r_exp - c_exp_w'(1)));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_bw    <= '0;
      r_num   <= '0;
      r_vals  <= '0;
      r_words <= '0;
      r_exp   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && bus.cfg_valid) begin
        r_num   <= bus.cfg_num_values;
        r_exp   <= w_exp_calc;
        r_err   <= w_illegal;
        r_vals  <= '0;
        r_words <= '0;
        if (!w_illegal) begin
          r_bw <= bus.cfg_bitwidth;
        end
      end
      if (r_state == ST_STREAM || r_state == ST_PAD) begin
        r_vals  <= w_vals_next;
        r_words <= w_words_next;
      end
    end
  end

  assign bus.cfg_ready     = w_cfg_ready;
  assign bus.s_ready       = w_s_ready;
  assign bus.cmp_clr_n     = w_clr_n;
  assign bus.cmp_bitwidth  = r_bw;
  assign bus.cmp_valid     = w_cmp_valid;
  assign bus.cmp_data      = w_cmp_data;
  assign bus.cmp_out_ready = w_out_ready;
  assign bus.m_valid       = w_m_valid;
  assign bus.m_data        = bus.cmp_out_data;
  assign bus.m_last        = w_m_last;
  assign bus.layer_done    = w_done;
  assign bus.layer_err     = w_err;

endmodule

`default_nettype wire
